// File: rtl/fdiv_pkg.sv
// Shared constants for the programmable clock divider.
package fdiv_pkg;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned DIV_MIN     = 2;
  localparam logic        MODE_SQUARE = 1'b0;
  localparam logic        MODE_PULSE  = 1'b1;
endpackage

// File: rtl/fdiv_if.sv
// Control/status bundle between the divider and its user logic.
interface fdiv_if import fdiv_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();
  logic             en;
  logic             sync_clr;
  logic             mode;
  logic             div_load;
  logic [CNT_W-1:0] div_in;
  logic             load_pend;
  logic             load_err;
  logic [CNT_W-1:0] div_active;
  logic             tick;
  logic             fout;

  modport master (
    output en, sync_clr, mode, div_load, div_in,
    input  load_pend, load_err, div_active, tick, fout
  );

  modport slave (
    input  en, sync_clr, mode, div_load, div_in,
    output load_pend, load_err, div_active, tick, fout
  );
endinterface

// File: rtl/fdiv_load_ctrl.sv
// Divisor load control: validates requests, holds a pending divisor and
// swaps it in at a period boundary (wrap or sync_clr). A request arriving on
// the boundary edge itself bypasses the pending register.
module fdiv_load_ctrl import fdiv_pkg::*; #(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DIV_DEFAULT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             wrap,
  input  logic             sync_clr,
  output logic [CNT_W-1:0] div_active,
  output logic             load_pend,
  output logic             load_err
);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);

  logic [CNT_W-1:0] pend_div;
  logic             load_ok;
  logic             boundary;

  assign load_ok  = div_load && (div_in >= DIV_LO);
  assign boundary = sync_clr || wrap;

  // Accept/reject requests and apply the newest valid divisor at a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_active <= DIV_RST;
      pend_div   <= '0;
      load_pend  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      load_err <= div_load && !load_ok;
      if (boundary) begin
        if (load_ok) begin
          div_active <= div_in;
        end else if (load_pend) begin
          div_active <= pend_div;
        end
        load_pend <= 1'b0;
      end else if (load_ok) begin
        pend_div  <= div_in;
        load_pend <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/fdiv_prog.sv
// Run-time programmable integer clock divider: square-wave or pulse output
// plus a one-cycle tick usable as a clock enable.
module fdiv_prog import fdiv_pkg::*; #(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DIV_DEFAULT = 50000000
) (
  input  logic  fin,
  input  logic  rst,
  fdiv_if.slave bus
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] half;
  logic             wrap;

  assign half = bus.div_active >> 1;
  // >= so a count left above a freshly shrunk divisor wraps immediately.
  assign wrap = bus.en && (count >= bus.div_active);

  fdiv_load_ctrl #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_load_ctrl (
    .clk        (fin),
    .rst        (rst),
    .div_load   (bus.div_load),
    .div_in     (bus.div_in),
    .wrap       (wrap),
    .sync_clr   (bus.sync_clr),
    .div_active (bus.div_active),
    .load_pend  (bus.load_pend),
    .load_err   (bus.load_err)
  );

  // Period counter 1..div_active with registered tick and fout.
  always_ff @(posedge fin) begin
    if (rst || bus.sync_clr) begin
      count    <= ONE;
      bus.fout <= 1'b0;
      bus.tick <= 1'b0;
    end else if (bus.en) begin
      count    <= wrap ? ONE : count + ONE;
      bus.tick <= wrap;
      case (bus.mode)
        MODE_SQUARE: bus.fout <= (count > half);
        MODE_PULSE:  bus.fout <= wrap;
        default:     bus.fout <= 1'b0;
      endcase
    end else begin
      bus.tick <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fdiv_prog.sv
// Bench for fdiv_prog: directed vector table, hand-written corner sequences
// and random stimulus, all checked against a period/phase reference model.
module tb_fdiv_prog;
  localparam int CW = 16;

  logic fin = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fdiv_if #(.CNT_W(CW)) bus ();

  fdiv_prog #(.CNT_W(CW), .DIV_DEFAULT(4)) dut (
    .fin (fin),
    .rst (rst),
    .bus (bus)
  );

  always #5 fin = ~fin;

  // Reference model: position within the current period (0-based), the
  // period length in use, and the pending divisor (-1 = none).
  int m_pos;
  int m_n;
  int m_pend;
  bit m_fout;
  bit m_tick;
  bit m_err;

  typedef struct {
    bit rst, en, sc, mode, ld;
    int din;
    bit fout, tick;
    int div;
    bit pend, err;
  } vec_t;
  vec_t vq[$];

  task automatic chk1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, bit e, bit s, bit m, bit l, int din);
    rst          = r;
    bus.en       = e;
    bus.sync_clr = s;
    bus.mode     = m;
    bus.div_load = l;
    bus.div_in   = din[CW-1:0];
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_edge();
    int din;
    bit ok;
    bit w;
    if (rst) begin
      m_pos = 0; m_n = 4; m_pend = -1;
      m_err = 0; m_tick = 0; m_fout = 0;
    end else begin
      din   = int'(bus.div_in);
      ok    = bus.div_load && din >= 2;
      m_err = bus.div_load && !ok;
      if (bus.sync_clr) begin
        if (ok) m_n = din;
        else if (m_pend >= 0) m_n = m_pend;
        m_pend = -1; m_pos = 0; m_fout = 0; m_tick = 0;
      end else begin
        w = 0;
        if (bus.en) begin
          w = (m_pos >= m_n - 1);
          // high phase is the last ceil(N/2) cycles of each period
          m_fout = bus.mode ? w : (m_pos >= m_n - (m_n + 1) / 2);
          m_tick = w;
          m_pos  = w ? 0 : m_pos + 1;
        end else begin
          m_tick = 0;
        end
        if (w) begin
          if (ok) m_n = din;
          else if (m_pend >= 0) m_n = m_pend;
          m_pend = -1;
        end else if (ok) begin
          m_pend = din;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge fin);
    @(negedge fin);
    chk1("model_fout", bus.fout, m_fout);
    chk1("model_tick", bus.tick, m_tick);
    chkw("model_div_active", 32'(bus.div_active), 32'(m_n));
    chk1("model_load_pend", bus.load_pend, m_pend >= 0);
    chk1("model_load_err", bus.load_err, m_err);
  endtask

  task automatic add(bit r, bit e, bit s, bit m, bit l, int din,
                     bit fo, bit tk, int dv, bit pd, bit er);
    vec_t v;
    v.rst = r; v.en = e; v.sc = s; v.mode = m; v.ld = l; v.din = din;
    v.fout = fo; v.tick = tk; v.div = dv; v.pend = pd; v.err = er;
    vq.push_back(v);
  endtask

  // Step until tick is seen; returns edges taken, or limit+1 if none.
  task automatic edges_to_tick(input int limit, output int n);
    n = limit + 1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (bus.tick === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    bit rmode;

    drive(1, 0, 0, 0, 0, 0);

    // rst en sc mode ld din | fout tick div pend err
    add(1,0,0,0,0,0, 0,0,4,0,0);
    add(0,1,0,0,0,0, 0,0,4,0,0);
    add(0,1,0,0,0,0, 0,0,4,0,0);
    add(0,1,0,0,0,0, 1,0,4,0,0);
    add(0,1,0,0,0,0, 1,1,4,0,0);
    add(0,1,0,0,0,0, 0,0,4,0,0);
    add(0,1,0,0,0,0, 0,0,4,0,0);
    add(0,1,0,0,0,0, 1,0,4,0,0);
    add(0,1,0,0,0,0, 1,1,4,0,0);
    add(0,1,0,0,1,1, 0,0,4,0,1);
    add(0,1,0,0,1,0, 0,0,4,0,1);
    add(0,1,0,0,0,0, 1,0,4,0,0);
    add(0,1,0,0,0,0, 1,1,4,0,0);
    add(1,1,0,0,0,0, 0,0,4,0,0);
    add(0,1,0,0,1,5, 0,0,4,1,0);
    add(0,1,0,0,0,0, 0,0,4,1,0);
    add(0,1,0,0,0,0, 1,0,4,1,0);
    add(0,1,0,0,0,0, 1,1,5,0,0);
    add(0,1,0,0,0,0, 0,0,5,0,0);
    add(0,1,0,0,0,0, 0,0,5,0,0);
    add(0,1,0,0,0,0, 1,0,5,0,0);
    add(0,1,0,0,0,0, 1,0,5,0,0);
    add(0,1,0,0,0,0, 1,1,5,0,0);
    add(0,1,0,0,0,0, 0,0,5,0,0);
    add(0,1,0,0,0,0, 0,0,5,0,0);
    add(0,1,0,0,0,0, 1,0,5,0,0);
    add(0,1,0,0,0,0, 1,0,5,0,0);
    add(0,1,0,0,1,3, 1,1,3,0,0);
    add(0,1,0,0,0,0, 0,0,3,0,0);
    add(0,1,0,0,0,0, 1,0,3,0,0);
    add(0,1,0,0,0,0, 1,1,3,0,0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].en, vq[i].sc, vq[i].mode, vq[i].ld, vq[i].din);
      step();
      chk1($sformatf("vec%0d_fout", i), bus.fout, vq[i].fout);
      chk1($sformatf("vec%0d_tick", i), bus.tick, vq[i].tick);
      chkw($sformatf("vec%0d_div", i), 32'(bus.div_active), 32'(vq[i].div));
      chk1($sformatf("vec%0d_pend", i), bus.load_pend, vq[i].pend);
      chk1($sformatf("vec%0d_err", i), bus.load_err, vq[i].err);
    end

    // Pulse mode, N=4, en dropped for 3 cycles mid-period.
    drive(1, 0, 0, 1, 0, 0); step();
    drive(0, 1, 0, 1, 0, 0); step(); step();
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("stall_tick", bus.tick, 1'b0);
    end
    drive(0, 1, 0, 1, 0, 0);
    edges_to_tick(10, n);
    chkw("pulse_stretch", 32'(n + 5), 32'd7);
    chk1("pulse_fout_at_tick", bus.fout, 1'b1);
    step();
    chk1("pulse_fout_after", bus.fout, 1'b0);

    // Pending load of 6, then sync_clr mid-period.
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0); step(); step();
    drive(0, 1, 0, 0, 1, 6); step();
    chk1("sc_pend_before", bus.load_pend, 1'b1);
    chk1("sc_fout_before", bus.fout, 1'b1);
    drive(0, 1, 1, 0, 0, 0); step();
    chkw("sc_div", 32'(bus.div_active), 32'd6);
    chk1("sc_pend", bus.load_pend, 1'b0);
    chk1("sc_fout", bus.fout, 1'b0);
    chk1("sc_tick", bus.tick, 1'b0);
    drive(0, 1, 0, 0, 0, 0);
    edges_to_tick(12, n);
    chkw("sc_period", 32'(n), 32'd6);

    // Pending load, then rst mid-period.
    drive(0, 1, 0, 0, 1, 7); step();
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step();
    chk1("rst_pend_before", bus.load_pend, 1'b1);
    drive(1, 1, 0, 0, 1, 1); step();
    chkw("rst_div", 32'(bus.div_active), 32'd4);
    chk1("rst_pend", bus.load_pend, 1'b0);
    chk1("rst_fout", bus.fout, 1'b0);
    chk1("rst_tick", bus.tick, 1'b0);
    chk1("rst_err", bus.load_err, 1'b0);

    // Random stimulus against the model.
    rmode = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 99) == 0) rmode = ~rmode;
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 99) < 85,
            $urandom_range(0, 59) == 0,
            rmode,
            $urandom_range(0, 24) == 0,
            int'($urandom_range(0, 12)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fdiv_prog.md
Name: fdiv_prog

Overview:
- Parametrised, run-time programmable successor to the fixed 50 MHz-to-1 Hz divider.
- Divides the board clock by a loadable integer N (2..2^CNT_W-1).
- Produces a square-wave output (duty ≈ 50%, high phase = ceil(N/2)) or a one-cycle pulse output, plus a single-cycle tick strobe usable as a clock enable.
- Sits between the board clock and the display/counter logic; sole source of slow enables.

Parameters:
- CNT_W, 32, width of counter and divisor.
- DIV_DEFAULT, 50000000, divisor loaded at reset (must be ≥2 and < 2^CNT_W).

Ports:
- fin, input, 1, board clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, count enable; low = freeze.
- sync_clr, input, 1, synchronous phase restart.
- mode, input, 1, 0 = square-wave fout, 1 = pulse fout.
- div_load, input, 1, one-cycle request to load div_in.
- div_in, input, CNT_W, requested divisor.
- load_pend, output, 1, a valid divisor is waiting for the period boundary.
- load_err, output, 1, one-cycle flag: div_load rejected.
- div_active, output, CNT_W, divisor currently in use.
- tick, output, 1, one-cycle strobe once per period.
- fout, output, 1, divided output.

Behaviour:
- Reset (rst=1 at posedge, overrides all other inputs):
  - count=1, div_active=DIV_DEFAULT, pend_div=0, load_pend=0.
  - load_err=0, tick=0, fout=0.
- Counter runs 1..div_active.
  - A wrap occurs on an enabled edge with count ≥ div_active. Then count←1, else count←count+1.
  - ≥ (not ==) means a count stranded above a newly applied smaller divisor wraps on the next enabled edge.
- half = div_active >> 1 (logical shift, CNT_W bits).
- Square mode (mode=0), registered on each enabled edge: fout ← (count > half), using the pre-increment count.
  - N=4: low 2, high 2 cycles. N=5: low 2, high 3 cycles. N=2: alternates every cycle.
- tick: registered; equals 1 for the cycle after a wrap edge, else 0. Exactly one tick per N enabled cycles.
- Pulse mode (mode=1): fout mirrors tick, registered identically (same cycle as tick).
  - Mode changes take effect on the next enabled edge; no glitch-free guarantee on the transition period.
- en=0: count, fout and div_active hold; tick forced 0 the following cycle.
  - div_load is still accepted while en=0.
- div_load handshake (sampled only when rst=0):
  - div_in < 2: reject. load_err=1 for one cycle; state unchanged; any existing pending value is kept.
  - Otherwise: pend_div←div_in, load_pend←1. A second valid load while pending overwrites pend_div (last wins).
  - The pending value is applied at the next wrap: div_active←pend_div, load_pend←0.
  - div_load on the wrap edge itself: div_in is applied at that wrap directly, and load_pend stays 0.
- sync_clr (priority below rst, above en):
  - count←1, fout←0, tick←0.
  - Any pending divisor is applied immediately and load_pend←0.
  - A valid div_load in the same cycle is applied directly.
- Latency: div_load to div_active change ≤ one full old period (plus 1 cycle).
  - Outputs are registered; no combinational path from inputs to outputs.
- No width growth: count never exceeds 2^CNT_W-1 because div_active < 2^CNT_W.

Decomposition:
- Package fdiv_pkg holds:
  - MODE_SQUARE=1'b0, MODE_PULSE=1'b1.
  - DIV_MIN=2.
  - Default CNT_W constant.
- One natural sub-module: fdiv_load_ctrl.
  - Owns pend_div, load_pend, load_err and the apply/bypass decision.
  - Inputs: div_load, div_in, wrap, sync_clr, rst.
  - Outputs: div_active, load_pend, load_err.
- The counter/output logic stays in fdiv_prog.

Test Plan:
- DIV_DEFAULT=4, en=1, mode=0 after reset -> fout pattern 0,0,1,1 repeating; tick high every 4th cycle; div_active=4.
- At reset load div_in=5, then observe -> load_pend=1 until first wrap; afterwards fout low 2 / high 3; tick every 5 cycles; load_pend=0.
- div_load with div_in=1, then div_in=0 -> load_err pulses 1 cycle each; div_active stays 4; load_pend unchanged.
- div_load div_in=3 asserted exactly on a wrap edge -> div_active=3 next cycle, load_pend never asserted, next tick 3 cycles later.
- mode=1, N=4; en dropped for 3 cycles mid-period -> fout equals tick (one high per 4 enabled cycles); period stretched by exactly 3; no tick while en=0.
- Pending load of 6, then sync_clr mid-period; separately rst mid-period -> sync_clr: div_active=6, count restarts, fout=0. rst: all outputs to reset values, div_active=DIV_DEFAULT.
